// File: rtl/mario_video_timing.sv
// Video timing generator for the Mario Bros board: pixel divider, horizontal/vertical
// counters, blank/sync strobes and line/frame/vblank event pulses.
module mario_video_timing #(
    parameter int CLK_DIV    = 2,
    parameter int H_W        = 10,
    parameter int H_TOTAL    = 768,
    parameter int H_BL_START = 511,
    parameter int H_BL_END   = 767,
    parameter int H_SY_START = 576,
    parameter int H_SY_END   = 640,
    parameter int V_LAST     = 255,
    parameter int V_WRAP_TO  = 504,
    parameter int V_BL_START = 239,
    parameter int V_BL_END   = 15
) (
    input  logic           I_CLK,
    input  logic           I_RST_n,
    input  logic           I_CE,
    input  logic           I_HFLIP,
    input  logic           I_VFLIP,
    output logic           O_PIX_CE,
    output logic           O_CLK,
    output logic [H_W-1:0] H_CNT,
    output logic [H_W-1:0] HF_CNT,
    output logic [8:0]     V_CNT,
    output logic [7:0]     VF_CNT,
    output logic           H_BLANKn,
    output logic           V_BLANKn,
    output logic           C_BLANKn,
    output logic           H_SYNCn,
    output logic           V_SYNCn,
    output logic           O_LINE_START,
    output logic           O_FRAME_START,
    output logic           O_VBL_IRQ
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic             HAS_PHASE = (CLK_DIV > 1);

    localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_BL_S  = H_W'(H_BL_START);
    localparam logic [H_W-1:0] H_BL_E  = H_W'(H_BL_END);
    localparam logic [H_W-1:0] H_SY_S  = H_W'(H_SY_START);
    localparam logic [H_W-1:0] H_SY_E  = H_W'(H_SY_END);
    localparam logic [8:0]     V_LST   = 9'(V_LAST);
    localparam logic [8:0]     V_WRAP  = 9'(V_WRAP_TO);
    localparam logic [8:0]     V_BL_S  = 9'(V_BL_START);
    localparam logic [8:0]     V_BL_E  = 9'(V_BL_END);

    logic [DIV_W-1:0] r_div;
    logic [H_W-1:0]   r_hcnt;
    logic [8:0]       r_vcnt;
    logic             r_hblank;
    logic             r_hsync;
    logic             r_vblank;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_vbl_irq;

    logic             w_tick;
    logic             w_line_adv;
    logic             w_vblank_next;

    assign w_tick     = I_CE && (r_div == DIV_LAST);
    assign w_line_adv = w_tick && (r_hcnt == H_SY_S);

    // Clear wins over set when both compare values coincide.
    always_comb begin
        w_vblank_next = r_vblank;
        if (r_vcnt == V_BL_E)
            w_vblank_next = 1'b0;
        else if (r_vcnt == V_BL_S)
            w_vblank_next = 1'b1;
    end

    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hblank      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vblank      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vbl_irq     <= 1'b0;
        end else begin
            r_line_start  <= w_line_adv;
            r_frame_start <= w_line_adv && (r_vcnt == V_LST);
            r_vbl_irq     <= w_line_adv && w_vblank_next && !r_vblank;

            if (I_CE)
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

            if (w_tick) begin
                r_hcnt <= (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;

                if (r_hcnt == H_BL_E)
                    r_hblank <= 1'b0;
                else if (r_hcnt == H_BL_S)
                    r_hblank <= 1'b1;

                if (r_hcnt == H_SY_E)
                    r_hsync <= 1'b0;
                else if (r_hcnt == H_SY_S)
                    r_hsync <= 1'b1;
            end

            if (w_line_adv) begin
                r_vcnt   <= (r_vcnt == V_LST) ? V_WRAP : r_vcnt + 1'b1;
                r_vblank <= w_vblank_next;
            end
        end
    end

    assign O_PIX_CE      = w_tick;
    assign O_CLK         = HAS_PHASE && (r_div >= DIV_HALF);
    assign H_CNT         = r_hcnt;
    assign HF_CNT        = r_hcnt ^ {H_W{I_HFLIP}};
    assign V_CNT         = r_vcnt;
    assign VF_CNT        = r_vcnt[7:0] ^ {8{I_VFLIP}};
    assign H_BLANKn      = ~r_hblank;
    assign V_BLANKn      = ~r_vblank;
    assign C_BLANKn      = ~(r_hblank | r_vblank);
    assign H_SYNCn       = ~r_hsync;
    assign V_SYNCn       = ~r_vcnt[8];
    assign O_LINE_START  = r_line_start;
    assign O_FRAME_START = r_frame_start;
    assign O_VBL_IRQ     = r_vbl_irq;

endmodule

// File: doc/mario_video_timing.md
MARIO_VIDEO_TIMING -- requirements
Module: mario_video_timing

Interface
REQ-001 Parameter CLK_DIV, default 2, master-clock cycles per pixel (>=1).
REQ-002 Parameter H_W, default 10, width of horizontal pixel count.
REQ-003 Parameter H_TOTAL, default 768, pixels per line (H_CNT runs 0..H_TOTAL-1).
REQ-004 Parameter H_BL_START / H_BL_END, default 511 / 767, horizontal blank set/clear compare values.
REQ-005 Parameter H_SY_START / H_SY_END, default 576 / 640, horizontal sync set/clear compare values; H_SY_START is also the line-advance point.
REQ-006 Parameter V_LAST / V_WRAP_TO, default 255 / 504, 9-bit line value after which V_CNT reloads, and the reload value.
REQ-007 Parameter V_BL_START / V_BL_END, default 239 / 15, vertical blank set/clear compare values.
REQ-008 I_CLK  in  1  master clock; the only clock.
REQ-009 I_RST_n  in  1  reset; asynchronous and active-low.
REQ-010 I_CE  in  1  master enable; when 0 all state holds.
REQ-011 I_HFLIP / I_VFLIP  in  1 each  horizontal / vertical flip select.
REQ-012 O_PIX_CE  out  1  one-I_CLK pulse per pixel tick.
REQ-013 O_CLK  out  1  pixel-rate clock phase, high for the second half of each divider period.
REQ-014 H_CNT  out  H_W  pixel count; HF_CNT  out  H_W  H_CNT XOR {H_W{I_HFLIP}}.
REQ-015 V_CNT  out  9  line count; VF_CNT  out  8  V_CNT[7:0] XOR {8{I_VFLIP}}.
REQ-016 H_BLANKn, V_BLANKn, C_BLANKn, H_SYNCn, V_SYNCn  out  1 each  active-low video timing strobes.
REQ-017 O_LINE_START, O_FRAME_START, O_VBL_IRQ  out  1 each  single-I_CLK event pulses.

Function
REQ-018 Divider counts 0..CLK_DIV-1 on cycles with I_CE=1; a tick is the cycle in which the divider equals CLK_DIV-1 and I_CE=1, and O_PIX_CE is 1 exactly then (combinational).
REQ-019 O_CLK is 1 when divider >= CLK_DIV/2 (integer division); CLK_DIV=1 drives O_CLK constantly 0.
REQ-020 On each tick, H_CNT becomes 0 if it equals H_TOTAL-1, otherwise H_CNT+1.
REQ-021 Horizontal flags update on ticks using the pre-increment H_CNT: H_BL_START sets H_BLANK, H_BL_END clears it, H_SY_START sets H_SYNC, H_SY_END clears it; the flag is visible from the following pixel onward.
REQ-022 If two compare values are equal, the clear takes priority over the set for that flag.
REQ-023 On a tick with H_CNT == H_SY_START, the line advances: V_CNT becomes V_WRAP_TO if it equals V_LAST, otherwise V_CNT+1 (9-bit wrap 511->0).
REQ-024 On a line advance, the pre-advance V_CNT is compared: V_BL_START sets V_BLANK, V_BL_END clears it, clear has priority.
REQ-025 V_SYNCn equals ~V_CNT[8]; H_SYNCn = ~H_SYNC; H_BLANKn = ~H_BLANK; V_BLANKn = ~V_BLANK; C_BLANKn = ~(H_BLANK | V_BLANK).
REQ-026 O_LINE_START is 1 for the single I_CLK cycle after every line advance.
REQ-027 O_FRAME_START is 1 for the single I_CLK cycle after a line advance that reloaded V_WRAP_TO.
REQ-028 O_VBL_IRQ is 1 for the single I_CLK cycle after V_BLANK goes 0->1.
REQ-029 I_HFLIP and I_VFLIP are purely combinational on the flipped outputs; they never alter H_CNT or V_CNT.
REQ-030 I_CE=0 freezes divider, counters, flags and suppresses O_PIX_CE; pending event pulses still complete their single cycle.
REQ-031 Default parameters reproduce the legacy Mario Bros timing: 768 pixels/line, 264 lines/frame (0..255, 504..511).

Reset
REQ-032 While I_RST_n=0: divider=0, H_CNT=0, V_CNT=0, all flags 0 (H_BLANKn, V_BLANKn, C_BLANKn, H_SYNCn, V_SYNCn = 1), all event pulses 0.
REQ-033 Reset asserted mid-line or mid-frame takes effect immediately, without waiting for an I_CLK edge; the first tick after release advances H_CNT to 1.

Verification
REQ-034 Reset release, I_CE=1, defaults -> O_PIX_CE every 2nd I_CLK; H_CNT 767->0; H_BLANKn low from H_CNT 512 through 767 inclusive, high at 0.
REQ-035 Run full frame -> V_CNT sequence ...,254,255,504,...,511,0; O_FRAME_START exactly once, following the 255->504 advance; V_SYNCn low only while V_CNT>=256.
REQ-036 Frame scan -> V_BLANKn falls after the advance from 239, rises after the advance from 15; O_VBL_IRQ one pulse per frame.
REQ-037 I_VFLIP=1 at V_CNT=3 -> VF_CNT=252; I_HFLIP=1 at H_CNT=5 -> HF_CNT=1018; H_CNT/V_CNT unchanged.
REQ-038 Hold I_CE=0 for 10 cycles mid-line -> all counters and strobes constant, no O_PIX_CE; resume continues from the held values.
REQ-039 Assert I_RST_n=0 between clock edges at V_CNT=100, H_CNT=600 -> all outputs take REQ-032 values immediately, without waiting for an I_CLK edge.
